proc_ctrl_fsm: RTL and testbench
================================

Name: proc_ctrl_fsm

Overview:
- Multicycle control unit that drives the shared 16-bit datapath bus.
- Fetches an instruction word into IR and decodes it.
- Sequences bus-source select codes (consumed by the bus multiplexer) and destination load enables for R0–R7, A, G and IR.
- Sits between the IR register and the bus mux/register file of the simple processor; executes mv, mvi, add, sub.

Parameters:
- IR_W, 16, instruction word width
- NREG, 8, number of general registers (one r_in bit each)

Ports:
- clock  in  1  system clock, rising edge
- reset  in  1  synchronous, active-high reset
- run  in  1  start request; sampled in IDLE
- ir  in  IR_W  current IR contents; opcode ir[15:12], rx ir[11:9], ry ir[8:6]
- select  out  4  bus source code: 0000 IR, 0001–1000 R0–R7, 1001 G, 1011 Rx field, 1100 Ry field
- rx  out  4  {1'b0, latched rx index} for bus mux indirect select
- ry  out  4  {1'b0, latched ry index}
- r_in  out  NREG  one-hot register load enable
- a_in  out  1  load A from bus
- g_in  out  1  load G with ALU result
- addsub  out  1  0 = add, 1 = subtract (valid with g_in)
- ir_in  out  1  load IR from external data word
- done  out  1  one-cycle pulse on the instruction's final cycle

Behaviour:
- Clock and reset: one clock; reset is synchronous and active-high. Reset forces state IDLE and clears latched rx/ry. All outputs read 0 from the next edge: select=0000, r_in=0, a_in=g_in=addsub=ir_in=done=0.
- Reset mid-instruction aborts with no further enables asserted.
- Opcodes: 0000 mv (Rx←Ry), 0001 mvi (Rx←next word), 0010 add (Rx←Rx+Ry), 0011 sub (Rx←Rx−Ry). Any other opcode is a NOP.
- Outputs are Moore/decoded from state, latched fields, and ir (T1 only). Unlisted outputs are 0 in every state.
- IDLE: when run=1, assert ir_in and go to T1. When run=0, stay in IDLE with all outputs 0.
- T1 (decode): capture rx=ir[11:9] and ry=ir[8:6] into internal registers at the T1 edge. The rx/ry outputs show ir fields combinationally in T1 and latched values afterwards.
  - mv: select=SRC(ry), r_in[rx]=1, done=1 → IDLE.
  - mvi: ir_in=1 (immediate word into IR) → T2.
  - add/sub: select=SRC(rx), a_in=1 → T2.
  - NOP: done=1 → IDLE; no load enables.
- T2:
  - mvi: select=0000, r_in[rx]=1, done=1 → IDLE.
  - add/sub: select=SRC(ry), g_in=1, addsub=(op==sub) → T3.
- T3: select=1001, r_in[rx]=1, done=1 → IDLE.
- Source encoding SRC(i):
  - index 0–6: 1011 when the source is the Rx field, 1100 when it is the Ry field.
  - index 7: always direct code 1000, because the bus mux's indirect path has no R7 case.
- Latency: mv and NOP take 2 cycles (IDLE+T1); mvi 3; add/sub 4. done marks the last cycle.
- Back-to-back: with run held high, a new fetch starts in the IDLE cycle right after done. There is no overlap.
- run is ignored outside IDLE.
- Only one r_in bit is ever high. r_in and ir_in are never high together.
- Rx==Ry is legal: add R3,R3 gives A=R3 and G=2·R3.

Decomposition:
- Shared package proc_ctrl_pkg holds:
  - opcode constants OP_MV, OP_MVI, OP_ADD, OP_SUB
  - select codes SEL_IR, SEL_R0..SEL_R7, SEL_G, SEL_RX, SEL_RY
  - state enum IDLE, T1, T2, T3
- One sub-module, sel_encode: combinational mapping from (index[2:0], field_is_rx) to the 4-bit select, including the index-7 direct-code rule.

Test Plan:
- Reset: assert reset mid-T2 of an add → next edge state IDLE, all outputs 0, no r_in pulse afterwards.
- mv R2←R5 (ir=16'h0540, run=1) → IDLE ir_in=1; T1 select=1100, r_in=8'b0000_0100, done=1; no cycle 3.
- mvi R1 (ir=16'h1200), immediate word 16'h00A5 → T1 ir_in=1; T2 select=0000, r_in=8'b0000_0010, done=1.
- add R0,R1 (ir=16'h2040):
  - T1: select=1011, a_in=1.
  - T2: select=1100, g_in=1, addsub=0.
  - T3: select=1001, r_in=8'b0000_0001, done=1.
- sub R7,R6 (ir=16'h3F80):
  - T1: select=1000 (direct R7), a_in=1.
  - T2: select=1100, addsub=1.
  - T3: r_in=8'b1000_0000.
- Illegal opcode 16'hF000 followed by back-to-back mv with run held high:
  - NOP gives done in T1 with r_in=0.
  - Next fetch's ir_in fires on the following cycle.

Source files
------------

// File: rtl/proc_ctrl_pkg.sv
// Shared definitions for the multicycle processor control unit:
// opcodes, bus-source select codes and the control state encoding.
package proc_ctrl_pkg;

    // Instruction opcodes held in ir[15:12]; every other value decodes as a NOP.
    localparam logic [3:0] OP_MV  = 4'b0000;
    localparam logic [3:0] OP_MVI = 4'b0001;
    localparam logic [3:0] OP_ADD = 4'b0010;
    localparam logic [3:0] OP_SUB = 4'b0011;

    // Bus multiplexer source codes.
    localparam logic [3:0] SEL_IR = 4'b0000;
    localparam logic [3:0] SEL_R0 = 4'b0001;
    localparam logic [3:0] SEL_R1 = 4'b0010;
    localparam logic [3:0] SEL_R2 = 4'b0011;
    localparam logic [3:0] SEL_R3 = 4'b0100;
    localparam logic [3:0] SEL_R4 = 4'b0101;
    localparam logic [3:0] SEL_R5 = 4'b0110;
    localparam logic [3:0] SEL_R6 = 4'b0111;
    localparam logic [3:0] SEL_R7 = 4'b1000;
    localparam logic [3:0] SEL_G  = 4'b1001;
    localparam logic [3:0] SEL_RX = 4'b1011;
    localparam logic [3:0] SEL_RY = 4'b1100;

    // Register index that the bus mux cannot reach through its indirect path.
    localparam logic [2:0] IDX_DIRECT_ONLY = 3'd7;

    // Control sequence states: IDLE fetches, T1 decodes, T2/T3 execute.
    typedef enum logic [1:0] {
        IDLE = 2'b00,
        T1   = 2'b01,
        T2   = 2'b10,
        T3   = 2'b11
    } state_t;

    // True for the two ALU instructions that share the A/G sequence.
    function automatic logic is_alu_op(input logic [3:0] op);
        is_alu_op = (op == OP_ADD) || (op == OP_SUB);
    endfunction

endpackage

// File: rtl/proc_ctrl_if.sv
// Control-unit boundary: instruction word and run request in,
// bus source select and destination load enables out.
interface proc_ctrl_if #(
    parameter int IR_W = 16,
    parameter int NREG = 8
);
    logic            run;
    logic [IR_W-1:0] ir;
    logic [3:0]      select;
    logic [3:0]      rx;
    logic [3:0]      ry;
    logic [NREG-1:0] r_in;
    logic            a_in;
    logic            g_in;
    logic            addsub;
    logic            ir_in;
    logic            done;

    // Controller side.
    modport master (
        input  run,
        input  ir,
        output select,
        output rx,
        output ry,
        output r_in,
        output a_in,
        output g_in,
        output addsub,
        output ir_in,
        output done
    );

    // Datapath side (bus mux, register file, IR).
    modport slave (
        output run,
        output ir,
        input  select,
        input  rx,
        input  ry,
        input  r_in,
        input  a_in,
        input  g_in,
        input  addsub,
        input  ir_in,
        input  done
    );
endinterface

// File: rtl/proc_ctrl_sel_encode.sv
// Maps a register index plus "which instruction field it came from" to the
// bus-mux source code. Indices 0-6 go through the mux's indirect Rx/Ry path;
// index 7 has no indirect case in the mux and so always uses its direct code.
module sel_encode
    import proc_ctrl_pkg::*;
(
    input  logic [2:0] index,
    input  logic       field_is_rx,
    output logic [3:0] select
);

    // Source code selection with the R7 direct-code override.
    always_comb begin
        select = SEL_IR;
        if (index == IDX_DIRECT_ONLY) begin
            select = SEL_R7;
        end else if (field_is_rx) begin
            select = SEL_RX;
        end else begin
            select = SEL_RY;
        end
    end

endmodule

// File: rtl/proc_ctrl_fsm.sv
// Multicycle control unit for the simple 16-bit processor. Fetches into IR,
// decodes mv / mvi / add / sub and sequences bus source selects and
// destination load enables. Outputs are decoded from the state, the
// latched instruction fields and, in T1 only, the live IR contents.
module proc_ctrl_fsm
    import proc_ctrl_pkg::*;
#(
    parameter int IR_W = 16,
    parameter int NREG = 8
) (
    input  logic        clock,
    input  logic        reset,
    proc_ctrl_if.master bus
);

    state_t          state_r;
    state_t          state_nxt_s;
    logic [3:0]      op_r;
    logic [2:0]      rx_r;
    logic [2:0]      ry_r;

    logic [3:0]      ir_op_s;
    logic [2:0]      ir_rx_s;
    logic [2:0]      ir_ry_s;
    logic            unused_ir_s;

    logic [3:0]      cur_op_s;
    logic [2:0]      cur_rx_s;
    logic [2:0]      cur_ry_s;
    logic [3:0]      sel_rx_s;
    logic [3:0]      sel_ry_s;

    logic [3:0]      select_s;
    logic [NREG-1:0] r_in_s;
    logic            a_in_s;
    logic            g_in_s;
    logic            addsub_s;
    logic            ir_in_s;
    logic            done_s;

    // One-hot load enable for general register idx.
    function automatic logic [NREG-1:0] reg_load(input logic [2:0] idx);
        reg_load = NREG'(1) << idx;
    endfunction

    assign ir_op_s     = bus.ir[IR_W-1 -: 4];
    assign ir_rx_s     = bus.ir[IR_W-5 -: 3];
    assign ir_ry_s     = bus.ir[IR_W-8 -: 3];
    assign unused_ir_s = ^bus.ir[IR_W-11:0];

    // In T1 the fields come straight from IR; afterwards IR may already hold
    // an immediate word, so the latched copies are used instead.
    always_comb begin
        cur_op_s = op_r;
        cur_rx_s = rx_r;
        cur_ry_s = ry_r;
        if (state_r == T1) begin
            cur_op_s = ir_op_s;
            cur_rx_s = ir_rx_s;
            cur_ry_s = ir_ry_s;
        end else begin
            cur_op_s = op_r;
            cur_rx_s = rx_r;
            cur_ry_s = ry_r;
        end
    end

    sel_encode u_sel_rx (
        .index       (cur_rx_s),
        .field_is_rx (1'b1),
        .select      (sel_rx_s)
    );

    sel_encode u_sel_ry (
        .index       (cur_ry_s),
        .field_is_rx (1'b0),
        .select      (sel_ry_s)
    );

    // State register and decode-time capture of opcode and register fields.
    always_ff @(posedge clock) begin
        if (reset) begin
            state_r <= IDLE;
            op_r    <= 4'd0;
            rx_r    <= 3'd0;
            ry_r    <= 3'd0;
        end else begin
            state_r <= state_nxt_s;
            if (state_r == T1) begin
                op_r <= ir_op_s;
                rx_r <= ir_rx_s;
                ry_r <= ir_ry_s;
            end
        end
    end

    // Next-state sequencing and per-state control decode.
    always_comb begin
        state_nxt_s = state_r;
        select_s    = SEL_IR;
        r_in_s      = '0;
        a_in_s      = 1'b0;
        g_in_s      = 1'b0;
        addsub_s    = 1'b0;
        ir_in_s     = 1'b0;
        done_s      = 1'b0;

        case (state_r)
            IDLE: begin
                // A fetch is never announced while reset holds the FSM in IDLE.
                if (bus.run && !reset) begin
                    ir_in_s     = 1'b1;
                    state_nxt_s = T1;
                end else begin
                    state_nxt_s = IDLE;
                end
            end

            T1: begin
                case (cur_op_s)
                    OP_MV: begin
                        select_s    = sel_ry_s;
                        r_in_s      = reg_load(cur_rx_s);
                        done_s      = 1'b1;
                        state_nxt_s = IDLE;
                    end
                    OP_MVI: begin
                        ir_in_s     = 1'b1;
                        state_nxt_s = T2;
                    end
                    OP_ADD, OP_SUB: begin
                        select_s    = sel_rx_s;
                        a_in_s      = 1'b1;
                        state_nxt_s = T2;
                    end
                    default: begin
                        done_s      = 1'b1;
                        state_nxt_s = IDLE;
                    end
                endcase
            end

            T2: begin
                if (cur_op_s == OP_MVI) begin
                    select_s    = SEL_IR;
                    r_in_s      = reg_load(cur_rx_s);
                    done_s      = 1'b1;
                    state_nxt_s = IDLE;
                end else if (is_alu_op(cur_op_s)) begin
                    select_s    = sel_ry_s;
                    g_in_s      = 1'b1;
                    addsub_s    = (cur_op_s == OP_SUB);
                    state_nxt_s = T3;
                end else begin
                    // Only mvi/add/sub ever reach T2; recover quietly otherwise.
                    state_nxt_s = IDLE;
                end
            end

            T3: begin
                select_s    = SEL_G;
                r_in_s      = reg_load(cur_rx_s);
                done_s      = 1'b1;
                state_nxt_s = IDLE;
            end

            default: begin
                state_nxt_s = IDLE;
            end
        endcase
    end

    assign bus.select = select_s;
    assign bus.rx     = {1'b0, cur_rx_s};
    assign bus.ry     = {1'b0, cur_ry_s};
    assign bus.r_in   = r_in_s;
    assign bus.a_in   = a_in_s;
    assign bus.g_in   = g_in_s;
    assign bus.addsub = addsub_s;
    assign bus.ir_in  = ir_in_s;
    assign bus.done   = done_s;

endmodule

// File: tb/tb_proc_ctrl_fsm.sv
// Self-checking bench for proc_ctrl_fsm. Each instruction is expanded into a
// per-cycle list of expected control outputs straight from the instruction
// rules, then driven and compared cycle by cycle.
module tb_proc_ctrl_fsm;

    logic clock = 1'b0;
    logic reset;

    proc_ctrl_if #(.IR_W(16), .NREG(8)) bus ();

    proc_ctrl_fsm #(.IR_W(16), .NREG(8)) dut (
        .clock (clock),
        .reset (reset),
        .bus   (bus.master)
    );

    always #5 clock = ~clock;

    typedef struct {
        logic [15:0] ir_word;
        logic        run_req;
        logic [3:0]  sel;
        logic [3:0]  rx;
        logic [3:0]  ry;
        logic [7:0]  r_in;
        logic        a_in;
        logic        g_in;
        logic        addsub;
        logic        ir_in;
        logic        done;
    } cyc_t;

    int       n_tests = 0;
    int       n_fail  = 0;
    int       n_instr = 0;
    logic [2:0] last_rx = 3'd0;
    logic [2:0] last_ry = 3'd0;
    cyc_t     plan_q[$];

    task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_tests++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    // Bus code for reading register idx through the given instruction field.
    function automatic logic [3:0] src_code(input logic [2:0] idx, input logic from_rx);
        if (idx == 3'd7) return 4'd8;
        return from_rx ? 4'd11 : 4'd12;
    endfunction

    function automatic logic [7:0] load_bit(input logic [2:0] idx);
        logic [7:0] one;
        one = 8'd1;
        return one << idx;
    endfunction

    // A cycle with every enable low and the given rx/ry indices shown.
    function automatic cyc_t quiet(input logic [2:0] x, input logic [2:0] y);
        cyc_t c;
        c.ir_word = 16'($urandom);
        c.run_req = 1'b0;
        c.sel     = 4'd0;
        c.rx      = {1'b0, x};
        c.ry      = {1'b0, y};
        c.r_in    = 8'd0;
        c.a_in    = 1'b0;
        c.g_in    = 1'b0;
        c.addsub  = 1'b0;
        c.ir_in   = 1'b0;
        c.done    = 1'b0;
        return c;
    endfunction

    // Expand one instruction into its expected cycles (fetch cycle first).
    task automatic build(input logic [15:0] instr, input logic [15:0] imm);
        logic [3:0] op;
        logic [2:0] x;
        logic [2:0] y;
        cyc_t c;
        op = instr[15:12];
        x  = instr[11:9];
        y  = instr[8:6];
        plan_q.delete();

        c = quiet(last_rx, last_ry);
        c.run_req = 1'b1;
        c.ir_in   = 1'b1;
        plan_q.push_back(c);

        c = quiet(x, y);
        c.ir_word = instr;
        if (op == 4'd0) begin
            c.sel  = src_code(y, 1'b0);
            c.r_in = load_bit(x);
            c.done = 1'b1;
            plan_q.push_back(c);
        end else if (op == 4'd1) begin
            c.ir_in = 1'b1;
            plan_q.push_back(c);
            c = quiet(x, y);
            c.ir_word = imm;
            c.r_in    = load_bit(x);
            c.done    = 1'b1;
            plan_q.push_back(c);
        end else if (op == 4'd2 || op == 4'd3) begin
            c.sel  = src_code(x, 1'b1);
            c.a_in = 1'b1;
            plan_q.push_back(c);
            c = quiet(x, y);
            c.ir_word = instr;
            c.sel     = src_code(y, 1'b0);
            c.g_in    = 1'b1;
            c.addsub  = (op == 4'd3);
            plan_q.push_back(c);
            c = quiet(x, y);
            c.ir_word = instr;
            c.sel     = 4'd9;
            c.r_in    = load_bit(x);
            c.done    = 1'b1;
            plan_q.push_back(c);
        end else begin
            c.done = 1'b1;
            plan_q.push_back(c);
        end
        last_rx = x;
        last_ry = y;
    endtask

    // Drive one cycle's inputs just after the rising edge, check at the falling edge.
    task automatic drive_check(input cyc_t e, input logic run_v, input string tag);
        bus.run = run_v;
        bus.ir  = e.ir_word;
        @(negedge clock);
        check_eq({tag, ".select"}, 32'(bus.select), 32'(e.sel));
        check_eq({tag, ".rx"},     32'(bus.rx),     32'(e.rx));
        check_eq({tag, ".ry"},     32'(bus.ry),     32'(e.ry));
        check_eq({tag, ".r_in"},   32'(bus.r_in),   32'(e.r_in));
        check_eq({tag, ".a_in"},   32'(bus.a_in),   32'(e.a_in));
        check_eq({tag, ".g_in"},   32'(bus.g_in),   32'(e.g_in));
        check_eq({tag, ".addsub"}, 32'(bus.addsub), 32'(e.addsub));
        check_eq({tag, ".ir_in"},  32'(bus.ir_in),  32'(e.ir_in));
        check_eq({tag, ".done"},   32'(bus.done),   32'(e.done));
    endtask

    task automatic next_cycle();
        @(posedge clock);
        #1;
    endtask

    // Run a whole instruction; run is random (and must be ignored) after the fetch cycle.
    task automatic exec(input logic [15:0] instr, input logic [15:0] imm);
        logic run_v;
        build(instr, imm);
        n_instr++;
        foreach (plan_q[k]) begin
            run_v = plan_q[k].run_req ? 1'b1 : 1'($urandom_range(0, 1));
            drive_check(plan_q[k], run_v, $sformatf("i%0d.c%0d", n_instr, k));
            next_cycle();
        end
    endtask

    task automatic idle(input int n);
        for (int i = 0; i < n; i++) begin
            drive_check(quiet(last_rx, last_ry), 1'b0, $sformatf("idle%0d", n_instr));
            next_cycle();
        end
    endtask

    initial begin
        logic [3:0]  op;
        logic [15:0] instr;

        reset   = 1'b1;
        bus.run = 1'b0;
        bus.ir  = 16'h0000;
        @(posedge clock);
        @(posedge clock);
        #1;
        // Held reset: no fetch even with run high, fields cleared.
        drive_check(quiet(3'd0, 3'd0), 1'b1, "reset");
        next_cycle();
        reset = 1'b0;
        idle(1);

        // Directed instructions.
        exec(16'h0540, 16'h0000);           // mv R2,R5
        exec(16'h1200, 16'h00A5);           // mvi R1,#A5
        exec(16'h2040, 16'h0000);           // add R0,R1
        exec(16'h3F80, 16'h0000);           // sub R7,R6
        exec(16'h26C0, 16'h0000);           // add R3,R3
        exec(16'hF000, 16'h0000);           // illegal -> NOP
        exec(16'h0E00, 16'h0000);           // back-to-back mv R7,R0
        exec(16'h11C0, 16'h5A5A);           // mvi R0 with ry=7
        idle(2);

        // Reset in the middle of T2 of an add.
        build(16'h2A40, 16'h0000);          // add R5,R1
        n_instr++;
        drive_check(plan_q[0], 1'b1, "rst.c0");
        next_cycle();
        drive_check(plan_q[1], 1'b0, "rst.c1");
        next_cycle();
        drive_check(plan_q[2], 1'b0, "rst.c2");
        reset = 1'b1;
        next_cycle();
        last_rx = 3'd0;
        last_ry = 3'd0;
        drive_check(quiet(3'd0, 3'd0), 1'b1, "rst.hold");
        next_cycle();
        reset = 1'b0;
        idle(3);

        // Randomized instruction stream with optional idle gaps.
        for (int n = 0; n < 300; n++) begin
            if ($urandom_range(0, 9) < 8) begin
                op = 4'($urandom_range(0, 3));
            end else begin
                op = 4'($urandom_range(4, 15));
            end
            instr = {op, 12'($urandom)};
            exec(instr, 16'($urandom));
            if ($urandom_range(0, 2) == 0) begin
                idle($urandom_range(1, 2));
            end
        end

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
